// File: rtl/castling_eval_sched_if.sv
// Requester, evaluator and response signals of castling_eval_sched.
// slave: the scheduler. master: the requesters plus the evaluator pair.
`ifndef BOARD_WIDTH
`define BOARD_WIDTH 64
`endif

interface castling_eval_sched_if #(
    parameter int EVAL_WIDTH = 32
);
    logic [1:0]                   req_valid;
    logic [1:0]                   req_ready;
    logic [`BOARD_WIDTH-1:0]      req0_board;
    logic [`BOARD_WIDTH-1:0]      req1_board;
    logic [3:0]                   req0_castle_mask;
    logic [3:0]                   req1_castle_mask;
    logic [3:0]                   req0_castle_mask_orig;
    logic [3:0]                   req1_castle_mask_orig;
    logic                         abort;
    logic                         ev_board_valid;
    logic [`BOARD_WIDTH-1:0]      ev_board;
    logic [3:0]                   ev_castle_mask;
    logic [3:0]                   ev_castle_mask_orig;
    logic signed [EVAL_WIDTH-1:0] ev_white_eval;
    logic signed [EVAL_WIDTH-1:0] ev_black_eval;
    logic                         ev_white_valid;
    logic                         ev_black_valid;
    logic [1:0]                   rsp_valid;
    logic signed [EVAL_WIDTH:0]   rsp_eval;
    logic                         busy;
    logic                         err_underflow;
    logic                         err_mismatch;

    modport slave (
        input  req_valid, req0_board, req1_board,
               req0_castle_mask, req1_castle_mask,
               req0_castle_mask_orig, req1_castle_mask_orig, abort,
               ev_white_eval, ev_black_eval, ev_white_valid, ev_black_valid,
        output req_ready, ev_board_valid, ev_board, ev_castle_mask, ev_castle_mask_orig,
               rsp_valid, rsp_eval, busy, err_underflow, err_mismatch
    );

    modport master (
        output req_valid, req0_board, req1_board,
               req0_castle_mask, req1_castle_mask,
               req0_castle_mask_orig, req1_castle_mask_orig, abort,
               ev_white_eval, ev_black_eval, ev_white_valid, ev_black_valid,
        input  req_ready, ev_board_valid, ev_board, ev_castle_mask, ev_castle_mask_orig,
               rsp_valid, rsp_eval, busy, err_underflow, err_mismatch
    );
endinterface

// File: rtl/castling_eval_sched.sv
// Round-robin sharing of one white/black castling evaluator pair between two
// requesters; a tag FIFO routes each summed result back to its requester.
`ifndef BOARD_WIDTH
`define BOARD_WIDTH 64
`endif

module castling_eval_sched #(
    parameter int EVAL_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    castling_eval_sched_if.slave bus
);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_e;

    state_e                       state_q, state_d;
    logic                         last_grant_q, last_grant_d;
    logic [MAX_OUTSTANDING-1:0]   tag_mem_q, tag_mem_d;
    logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]             rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]             count_q, count_d;
    logic                         ev_board_valid_q, ev_board_valid_d;
    logic [`BOARD_WIDTH-1:0]      ev_board_q, ev_board_d;
    logic [3:0]                   ev_mask_q, ev_mask_d;
    logic [3:0]                   ev_mask_orig_q, ev_mask_orig_d;
    logic [1:0]                   rsp_valid_q, rsp_valid_d;
    logic [EVAL_WIDTH:0]          rsp_eval_q, rsp_eval_d;
    logic                         busy_q, busy_d;
    logic                         err_underflow_q, err_underflow_d;
    logic                         err_mismatch_q, err_mismatch_d;

    logic [1:0]                   grant_s;
    logic                         push_s;
    logic                         pop_s;
    logic                         pop_tag_s;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        if (p == PTR_LAST) begin
            ptr_next = {PTR_W{1'b0}};
        end else begin
            ptr_next = p + PTR_W'(1);
        end
    endfunction

    function automatic logic [EVAL_WIDTH:0] eval_sum(input logic [EVAL_WIDTH-1:0] w,
                                                     input logic [EVAL_WIDTH-1:0] b);
        eval_sum = {w[EVAL_WIDTH-1], w} + {b[EVAL_WIDTH-1], b};
    endfunction

    // Slot check uses the registered count, so a pop never frees a slot in its own cycle.
    always_comb begin
        grant_s = 2'b00;
        if ((state_q == ST_RUN) && (count_q < CNT_MAX) && !bus.abort) begin
            case (bus.req_valid)
                2'b01:   grant_s = 2'b01;
                2'b10:   grant_s = 2'b10;
                2'b11:   grant_s = (last_grant_q == 1'b1) ? 2'b01 : 2'b10;
                default: grant_s = 2'b00;
            endcase
        end else begin
            grant_s = 2'b00;
        end
    end

    assign push_s    = grant_s != 2'b00;
    assign pop_s     = bus.ev_white_valid && (count_q != {CNT_W{1'b0}});
    assign pop_tag_s = tag_mem_q[rd_ptr_q];

    always_comb begin
        state_d          = state_q;
        last_grant_d     = last_grant_q;
        tag_mem_d        = tag_mem_q;
        wr_ptr_d         = wr_ptr_q;
        rd_ptr_d         = rd_ptr_q;
        count_d          = count_q;
        ev_board_valid_d = 1'b0;
        ev_board_d       = ev_board_q;
        ev_mask_d        = ev_mask_q;
        ev_mask_orig_d   = ev_mask_orig_q;
        rsp_valid_d      = 2'b00;
        rsp_eval_d       = rsp_eval_q;

        case (state_q)
            ST_RUN:   state_d = bus.abort ? ST_DRAIN : ST_RUN;
            ST_DRAIN: state_d = (count_q == {CNT_W{1'b0}}) ? ST_RUN : ST_DRAIN;
            default:  state_d = ST_RUN;
        endcase

        if (push_s) begin
            tag_mem_d[wr_ptr_q] = grant_s[1];
            wr_ptr_d            = ptr_next(wr_ptr_q);
            last_grant_d        = grant_s[1];
            ev_board_valid_d    = 1'b1;
            ev_board_d          = grant_s[1] ? bus.req1_board : bus.req0_board;
            ev_mask_d           = grant_s[1] ? bus.req1_castle_mask : bus.req0_castle_mask;
            ev_mask_orig_d      = grant_s[1] ? bus.req1_castle_mask_orig
                                             : bus.req0_castle_mask_orig;
        end else begin
            ev_board_valid_d    = 1'b0;
        end

        // Results popped while draining are consumed but never reported.
        if (pop_s) begin
            rd_ptr_d = ptr_next(rd_ptr_q);
            if (state_q == ST_RUN) begin
                rsp_valid_d = pop_tag_s ? 2'b10 : 2'b01;
                rsp_eval_d  = eval_sum(bus.ev_white_eval, bus.ev_black_eval);
            end else begin
                rsp_valid_d = 2'b00;
            end
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        err_underflow_d = err_underflow_q | (bus.ev_white_valid && (count_q == {CNT_W{1'b0}}));
        err_mismatch_d  = err_mismatch_q  | (bus.ev_white_valid != bus.ev_black_valid);
        busy_d          = (state_d == ST_DRAIN) || (count_d != {CNT_W{1'b0}});
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= ST_RUN;
            last_grant_q     <= 1'b1;
            tag_mem_q        <= {MAX_OUTSTANDING{1'b0}};
            wr_ptr_q         <= {PTR_W{1'b0}};
            rd_ptr_q         <= {PTR_W{1'b0}};
            count_q          <= {CNT_W{1'b0}};
            ev_board_valid_q <= 1'b0;
            ev_board_q       <= {`BOARD_WIDTH{1'b0}};
            ev_mask_q        <= 4'b0000;
            ev_mask_orig_q   <= 4'b0000;
            rsp_valid_q      <= 2'b00;
            rsp_eval_q       <= {(EVAL_WIDTH+1){1'b0}};
            busy_q           <= 1'b0;
            err_underflow_q  <= 1'b0;
            err_mismatch_q   <= 1'b0;
        end else begin
            state_q          <= state_d;
            last_grant_q     <= last_grant_d;
            tag_mem_q        <= tag_mem_d;
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            count_q          <= count_d;
            ev_board_valid_q <= ev_board_valid_d;
            ev_board_q       <= ev_board_d;
            ev_mask_q        <= ev_mask_d;
            ev_mask_orig_q   <= ev_mask_orig_d;
            rsp_valid_q      <= rsp_valid_d;
            rsp_eval_q       <= rsp_eval_d;
            busy_q           <= busy_d;
            err_underflow_q  <= err_underflow_d;
            err_mismatch_q   <= err_mismatch_d;
        end
    end

    assign bus.req_ready           = grant_s;
    assign bus.ev_board_valid      = ev_board_valid_q;
    assign bus.ev_board            = ev_board_q;
    assign bus.ev_castle_mask      = ev_mask_q;
    assign bus.ev_castle_mask_orig = ev_mask_orig_q;
    assign bus.rsp_valid           = rsp_valid_q;
    assign bus.rsp_eval            = rsp_eval_q;
    assign bus.busy                = busy_q;
    assign bus.err_underflow       = err_underflow_q;
    assign bus.err_mismatch        = err_mismatch_q;
endmodule
